fetch_unit: RTL and testbench

//   Instruction-fetch stage of the 3-stage pipeline; sits directly upstream of the IF/EX pipeline register.

---
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage feeding the IF/EX pipeline register.
//
// Generates sequential fetch PCs, issues in-order requests to instruction
// memory and buffers the returning words in a FIFO_DEPTH-entry queue. The
// head of the queue is presented to the pipeline register each cycle, or a
// NOP bubble when the head has no instruction yet. A branch redirect flushes
// the queue and remembers how many wrong-path responses are still in flight
// so they can be silently discarded when they arrive.
//
// Parameters:
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  fetch-queue entries (power of 2, >= 2)
//   NOP_INSTR   bubble instruction
//
// Ports:
//   clock, reset       clock; synchronous active-high reset
//   stall              downstream hold, head entry is not consumed
//   branch_taken       redirect request from execute
//   branch_target      redirect PC (low two bits ignored)
//   imem_req/addr      fetch request and its address
//   imem_gnt           request accepted when imem_req & imem_gnt
//   imem_rvalid/rdata  in-order instruction response
//   pc_next            PC of presented instruction (0 on bubble)
//   machine_code       presented instruction (NOP_INSTR on bubble)
//   fetch_valid        1 when a real instruction is presented
//   fetch_bubbles      (FETCH_PERF_EN only) saturating bubble-cycle count
//   fetch_flushes      (FETCH_PERF_EN only) saturating redirect count
//
// Optional feature: define FETCH_PERF_EN to add the two performance counters.

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_next,
  output logic [31:0] machine_code,
  output logic        fetch_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_bubbles,
  output logic [31:0] fetch_flushes
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(FIFO_DEPTH + 1) + 1;

  // Fetch-address state
  logic [31:0]   fetch_pc_p0;

  // Queue control. Entries fill in allocation order, so the unfilled ones
  // are always the youngest: the head is filled exactly when more entries
  // are allocated than are waiting, and the next entry to fill sits
  // unfill_cnt slots behind the tail.
  logic [AW-1:0] head_ptr;
  logic [AW-1:0] tail_ptr;
  logic [CW-1:0] alloc_cnt;
  logic [CW-1:0] unfill_cnt;
  logic [DW-1:0] drop_cnt;

  // Queue storage
  logic [31:0]   q_pc_p1    [FIFO_DEPTH];
  logic [31:0]   q_instr_p1 [FIFO_DEPTH];

  logic          vld_p1;
  logic          pop;
  logic          grant;
  logic          fill;
  logic          drop_rsp;
  logic [AW-1:0] fill_idx;

  assign vld_p1   = !reset && (alloc_cnt != unfill_cnt);
  assign pop      = vld_p1 && !stall && !branch_taken;
  // A slot released by this cycle's pop may be re-allocated in the same
  // cycle, which keeps a full queue streaming at one instruction per cycle.
  assign imem_req = !reset && !branch_taken &&
                    ((alloc_cnt - CW'(pop)) < CW'(FIFO_DEPTH));
  assign imem_addr = fetch_pc_p0;
  assign grant    = imem_req && imem_gnt;
  assign drop_rsp = imem_rvalid && (drop_cnt != '0);
  assign fill     = imem_rvalid && (drop_cnt == '0);
  assign fill_idx = tail_ptr - unfill_cnt[AW-1:0];

  assign fetch_valid  = vld_p1;
  assign pc_next      = vld_p1 ? q_pc_p1[head_ptr]    : 32'h0000_0000;
  assign machine_code = vld_p1 ? q_instr_p1[head_ptr] : NOP_INSTR;

  // Stage p0 -> p1: fetch PC, queue pointers and discard counter
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_p0 <= RESET_PC;
      head_ptr    <= '0;
      tail_ptr    <= '0;
      alloc_cnt   <= '0;
      unfill_cnt  <= '0;
      drop_cnt    <= '0;
    end else if (branch_taken) begin
      // Every outstanding request becomes wrong-path; a response arriving
      // this very cycle retires one of them.
      fetch_pc_p0 <= branch_target & ~32'h0000_0003;
      head_ptr    <= '0;
      tail_ptr    <= '0;
      alloc_cnt   <= '0;
      unfill_cnt  <= '0;
      drop_cnt    <= drop_cnt + DW'(unfill_cnt) - DW'(imem_rvalid);
    end else begin
      if (grant) begin
        fetch_pc_p0 <= fetch_pc_p0 + 32'd4;
        tail_ptr    <= tail_ptr + AW'(1);
      end
      if (pop) begin
        head_ptr <= head_ptr + AW'(1);
      end
      alloc_cnt  <= alloc_cnt + CW'(grant) - CW'(pop);
      unfill_cnt <= unfill_cnt + CW'(grant) - CW'(fill);
      if (drop_rsp) begin
        drop_cnt <= drop_cnt - DW'(1);
      end
    end
  end

  // Stage p1 data: entry payload, written on allocation and on response
  always_ff @(posedge clock) begin
    if (grant) begin
      q_pc_p1[tail_ptr] <= fetch_pc_p0;
    end
    if (fill) begin
      q_instr_p1[fill_idx] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_bubbles <= '0;
      fetch_flushes <= '0;
    end else begin
      if (!stall && !branch_taken && !fetch_valid && (fetch_bubbles != 32'hFFFF_FFFF)) begin
        fetch_bubbles <= fetch_bubbles + 32'd1;
      end
      if (branch_taken && (fetch_flushes != 32'hFFFF_FFFF)) begin
        fetch_flushes <= fetch_flushes + 32'd1;
      end
    end
  end
`endif

  // A response must always belong to an outstanding request.
  rvalid_has_owner: assert property (@(posedge clock) disable iff (reset)
    imem_rvalid |-> ((drop_cnt != '0) || (unfill_cnt != '0)));

  drop_cnt_bounded: assert property (@(posedge clock) disable iff (reset)
    drop_cnt <= DW'(2 * FIFO_DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- randomized bench for fetch_unit with an in-bench
// reference model (queue of {pc, instr, filled} entries) and a few
// hand-computed directed expectations.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] XORK   = 32'hA5A5_0000;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_next;
  logic [31:0] machine_code;
  logic        fetch_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_bubbles;
  logic [31:0] fetch_flushes;
`endif

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .pc_next      (pc_next),
    .machine_code (machine_code),
    .fetch_valid  (fetch_valid)
`ifdef FETCH_PERF_EN
    ,
    .fetch_bubbles(fetch_bubbles),
    .fetch_flushes(fetch_flushes)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  bit rnd_mode   = 0;
  int dir_lat    = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the fetch queue as a list of entries, plus the
  // memory's list of granted-but-unanswered requests.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } ent_t;
  typedef struct {
    logic [31:0] addr;
    int          ready;
  } mem_t;

  ent_t        mq[$];
  mem_t        pend[$];
  logic [31:0] m_pc;
  int          m_drop;
  bit          m_live = 0;
  logic [31:0] m_bub;
  logic [31:0] m_fl;

  bit          e_valid, e_req, pop_now, m_grant;
  logic [31:0] e_pc, e_instr;
  int          occ, unf;
  bit          filled_one;

  // Memory responder: answers in order once the chosen latency has elapsed.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (pend.size() > 0 && pend[0].ready <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].addr ^ XORK;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  always @(negedge clock) begin
    if (reset) m_live = 1;
    if (m_live) begin
      e_valid = !reset && mq.size() > 0 && mq[0].filled;
      e_pc    = e_valid ? mq[0].pc : 32'h0;
      e_instr = e_valid ? mq[0].instr : NOP;
      pop_now = e_valid && !stall && !branch_taken;
      occ     = mq.size() - (pop_now ? 1 : 0);
      e_req   = !reset && !branch_taken && (occ < DEPTH);

      check("fetch_valid", {31'b0, fetch_valid}, {31'b0, e_valid});
      check("pc_next", pc_next, e_pc);
      check("machine_code", machine_code, e_instr);
      check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
      if (e_req) check("imem_addr", imem_addr, m_pc);
`ifdef FETCH_PERF_EN
      check("fetch_bubbles", fetch_bubbles, m_bub);
      check("fetch_flushes", fetch_flushes, m_fl);
`endif

      if (reset) begin
        m_pc   = RST_PC;
        m_drop = 0;
        m_bub  = 0;
        m_fl   = 0;
        mq.delete();
        pend.delete();
      end else begin
        if (!stall && !branch_taken && !e_valid && m_bub != 32'hFFFF_FFFF) m_bub++;
        if (branch_taken && m_fl != 32'hFFFF_FFFF) m_fl++;
        m_grant = e_req && imem_gnt;
        if (m_grant)
          pend.push_back('{addr: m_pc, ready: cyc + (rnd_mode ? int'($urandom_range(1, 3)) : dir_lat)});
        if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
        if (branch_taken) begin
          unf = 0;
          foreach (mq[i]) if (!mq[i].filled) unf++;
          m_drop = m_drop + unf - (imem_rvalid ? 1 : 0);
          mq.delete();
          m_pc = branch_target & ~32'h3;
        end else begin
          if (imem_rvalid) begin
            if (m_drop > 0) m_drop--;
            else begin
              filled_one = 0;
              foreach (mq[i]) begin
                if (!filled_one && !mq[i].filled) begin
                  mq[i].instr  = imem_rdata;
                  mq[i].filled = 1;
                  filled_one   = 1;
                end
              end
            end
          end
          if (pop_now) void'(mq.pop_front());
          if (m_grant) begin
            mq.push_back('{pc: m_pc, instr: 32'h0, filled: 0});
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [31:0] vpcs[$];
  int          first_idx;
  bit          found;

  initial begin
    reset = 1; stall = 0; branch_taken = 0; branch_target = 0;
    imem_gnt = 1; imem_rvalid = 0; imem_rdata = 0;

    // Reset state
    tick(); tick();
    @(negedge clock);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_valid", {31'b0, fetch_valid}, 32'h0);
    check("rst_mc", machine_code, 32'h0000_0013);
    check("rst_pc", pc_next, 32'h0);

    // Streaming from reset, including the 0xFFFF_FFFC -> 0 wrap
    tick(); reset = 0;
    first_idx = -1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      @(negedge clock);
      if (fetch_valid) begin
        if (first_idx < 0) first_idx = i;
        vpcs.push_back(pc_next);
      end
    end
    check("first_valid_cycle", first_idx, 2);
    check("stream_count", vpcs.size(), 6);
    if (vpcs.size() >= 4) begin
      check("stream_pc0", vpcs[0], 32'hFFFF_FFFC);
      check("stream_pc1", vpcs[1], 32'h0000_0000);
      check("stream_pc2", vpcs[2], 32'h0000_0004);
      check("stream_pc3", vpcs[3], 32'h0000_0008);
    end

    // Stall: head frozen, queue fills, request drops
    for (int i = 0; i < 4; i++) begin
      tick(); stall = 1;
      @(negedge clock);
      check("stall_pc", pc_next, 32'h0000_0014);
      check("stall_req", {31'b0, imem_req}, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      tick(); stall = 0;
      @(negedge clock);
      check("release_pc", pc_next, 32'h0000_0014 + 32'(4 * i));
      check("release_valid", {31'b0, fetch_valid}, 32'h1);
    end

    // Redirect with requests in flight
    dir_lat = 3;
    tick(); tick();
    tick(); branch_taken = 1; branch_target = 32'h0000_0102;
    @(negedge clock);
    check("branch_req", {31'b0, imem_req}, 32'h0);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick(); branch_taken = 0;
      @(negedge clock);
      if (fetch_valid) begin
        found = 1;
        check("redirect_pc", pc_next, 32'h0000_0100);
        check("redirect_mc", machine_code, 32'h0000_0100 ^ XORK);
      end
    end
    check("redirect_seen", {31'b0, found}, 32'h1);
`ifdef FETCH_PERF_EN
    check("perf_flushes", fetch_flushes, 32'h1);
`endif
    dir_lat = 1;

    // No grant for 5 cycles after reset
    tick(); reset = 1; imem_gnt = 0;
    tick(); reset = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      @(negedge clock);
      check("nognt_addr", imem_addr, 32'hFFFF_FFFC);
      check("nognt_valid", {31'b0, fetch_valid}, 32'h0);
      check("nognt_mc", machine_code, 32'h0000_0013);
      check("nognt_pc", pc_next, 32'h0);
    end
    tick(); imem_gnt = 1;
`ifdef FETCH_PERF_EN
    @(negedge clock);
    check("perf_bubbles", fetch_bubbles, 32'd5);
`endif
    for (int i = 0; i < 6; i++) tick();

    // Randomized traffic checked by the model
    rnd_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset         = ($urandom % 200) == 0;
      stall         = ($urandom % 4) == 0;
      branch_taken  = ($urandom % 20) == 0;
      branch_target = $urandom;
      imem_gnt      = ($urandom % 10) < 7;
    end
    tick(); reset = 0; stall = 0; branch_taken = 0; imem_gnt = 1;
    for (int i = 0; i < 8; i++) tick();
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
